pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline controller for the IF/ID register and the rest of the 5-stage pipe.
//  Detects load-use hazards, taken-beq flushes and data-memory wait states.
//  Drives hazard_hold/hazard_flush into IF/ID, PC write enable, an ID/EX bubble and a global freeze.
//  Keeps saturating stall/flush performance counters.
// PARAMETERS
//  MEM_WAIT  2   data-memory stall cycles per lw/sw reaching MEM (0 = no wait states)
//  CNT_W     16  width of perf counters
// PORTS
//  clock          in   1      rising-edge clock
//  reset          in   1      synchronous, active-low
//  id_inst        in   32     instruction currently in ID (IF/ID Instreg)
//  idex_memread   in   1      instruction in EX is a load
//  idex_rt        in   5      destination rt of the instruction in EX
//  ex_branch_taken in  1      beq in EX resolved taken this cycle
//  exmem_memop    in   1      lw or sw present in MEM this cycle
//  hazard_hold    out  1      to IF/ID: hold Instreg/pc4_reg
//  hazard_flush   out  1      to IF/ID: replace Instreg with nop
//  pc_write       out  1      PC register load enable
//  idex_bubble    out  1      zero ID/EX control fields
//  mem_stall      out  1      freeze IF/ID, ID/EX, EX/MEM, MEM/WB and PC
//  stall_cnt      out  CNT_W  cycles with hazard_hold=1, saturating
//  flush_cnt      out  CNT_W  cycles with hazard_flush=1, saturating
// BEHAVIOUR
//  Decode: op=id_inst[31:26], rs=[25:21], rt=[20:16].
//   uses_rs = op not in {0x02,0x03}.
//   uses_rt = op in {0x00,0x04,0x05,0x2B}.
//  load_use = idex_memread & idex_rt!=0 & ((uses_rs & rs==idex_rt) | (uses_rt & rt==idex_rt)).
//  FSM: RUN, WAIT. 
//   RUN: mem_trig = exmem_memop & MEM_WAIT!=0; on mem_trig, cnt<=MEM_WAIT-1, go WAIT.
//   WAIT: if cnt!=0, cnt<=cnt-1; if cnt==0, go RUN.
//  mem_stall = (RUN & mem_trig) | (WAIT & cnt!=0). It is high for exactly MEM_WAIT cycles per op.
//  The WAIT cnt==0 cycle is unstalled, so the op leaves MEM; a new op can trigger in the next RUN cycle.
//  Only RUN can trigger, so an op is never counted twice.
//  Outputs are combinational, evaluated in this priority order:
//   1 mem_stall: hold=1, pc_write=0, flush=0, bubble=0. The whole pipe freezes; a pending branch/load-use waits.
//   2 ex_branch_taken: flush=1, bubble=1, hold=0, pc_write=1 (PC takes target). load_use is ignored (wrong path).
//   3 load_use: hold=1, pc_write=0, bubble=1, flush=0. This lasts 1 cycle; the bubble clears idex_memread.
//   4 otherwise: hold=0, flush=0, bubble=0, pc_write=1.
//  Never assert hazard_flush and hazard_hold together (IF/ID gives flush priority).
//  Counters (registered): stall_cnt+=1 when hazard_hold; flush_cnt+=1 when hazard_flush. Saturate at all-ones, no wrap.
//  Reset (reset==0 at posedge): state<=RUN, cnt<=0, stall_cnt<=0, flush_cnt<=0.
//   While reset==0, outputs are hold=0, flush=0, mem_stall=0, pc_write=0, bubble=1.
//   Reset mid-WAIT aborts the wait; mem_stall is 0 in the first cycle after release unless exmem_memop is set.
//  Simultaneous: taken branch + load_use -> branch only. exmem_memop + branch -> stall, then flush in the first unstalled cycle.
// TESTING
//  T1 idex_memread=1, idex_rt=8, id_inst=0x010A4820 (add $9,$8,$10)
//     -> hold=1, pc_write=0, bubble=1 for 1 cycle; stall_cnt=1.
//  T2 same as T1 with idex_rt=0, and separately id_inst=0x08000010 (j) with idex_rt=8
//     -> no hold, pc_write=1.
//  T3 ex_branch_taken=1 together with the T1 load_use
//     -> flush=1, bubble=1, hold=0, pc_write=1; flush_cnt=1, stall_cnt unchanged.
//  T4 MEM_WAIT=3, exmem_memop=1 held
//     -> mem_stall=1,1,1,0 then retriggers.
//     Branch_taken raised during the stall -> flush=1 only in the first mem_stall=0 cycle.
//  T5 reset=0 for 1 cycle during WAIT (cnt=1), exmem_memop=0
//     -> next cycle state RUN, mem_stall=0, both counters 0.
//  T6 load_use held for 65540 cycles -> stall_cnt reaches 0xFFFF and stays there; no wrap to 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// master = datapath side, slave = controller side.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_inst;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic             ex_branch_taken;
  logic             exmem_memop;
  logic             hazard_hold;
  logic             hazard_flush;
  logic             pc_write;
  logic             idex_bubble;
  logic             mem_stall;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_inst, idex_memread, idex_rt,
    output ex_branch_taken, exmem_memop,
    input  hazard_hold, hazard_flush, pc_write,
    input  idex_bubble, mem_stall,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_inst, idex_memread, idex_rt,
    input  ex_branch_taken, exmem_memop,
    output hazard_hold, hazard_flush, pc_write,
    output idex_bubble, mem_stall,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipe controller: load-use stall, taken-beq flush,
// data-memory wait states and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input logic               clock,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    (MEM_WAIT > 0) ? CW'(MEM_WAIT - 1) : '0;
  localparam bit HAS_WAIT = (MEM_WAIT != 0);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [5:0]       op;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             uses_rs;
  logic             uses_rt;
  logic             load_use;
  logic             mem_trig;
  logic             stall;
  logic             sel_rst;
  logic             sel_stall;
  logic             sel_br;
  logic             sel_lu;
  logic             hold;
  logic             flush;
  logic             pcw;
  logic             bub;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             unused_bits;

  assign op = hz.id_inst[31:26];
  assign rs = hz.id_inst[25:21];
  assign rt = hz.id_inst[20:16];
  assign unused_bits = ^hz.id_inst[15:0];

  assign uses_rs = !(op == 6'h02 || op == 6'h03);
  assign uses_rt = (op == 6'h00) || (op == 6'h04) ||
                   (op == 6'h05) || (op == 6'h2B);

  assign load_use = hz.idex_memread && (hz.idex_rt != 5'd0) &&
                    ((uses_rs && rs == hz.idex_rt) ||
                     (uses_rt && rt == hz.idex_rt));

  assign mem_trig = hz.exmem_memop && HAS_WAIT;
  assign stall = reset &&
                 ((state == S_RUN && mem_trig) ||
                  (state == S_WAIT && cnt != '0));

  // one-hot selects so the decoder below is truly unique
  assign sel_rst   = !reset;
  assign sel_stall = stall;
  assign sel_br    = reset && !stall && hz.ex_branch_taken;
  assign sel_lu    = reset && !stall &&
                     !hz.ex_branch_taken && load_use;

  always_comb begin
    hold  = 1'b0;
    flush = 1'b0;
    pcw   = 1'b1;
    bub   = 1'b0;
    unique case (1'b1)
      sel_rst: begin
        pcw = 1'b0;
        bub = 1'b1;
      end
      sel_stall: begin
        hold = 1'b1;
        pcw  = 1'b0;
      end
      sel_br: begin
        flush = 1'b1;
        bub   = 1'b1;
      end
      sel_lu: begin
        hold = 1'b1;
        pcw  = 1'b0;
        bub  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (mem_trig) begin
            cnt   <= CNT_INIT;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hold && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.hazard_hold  = hold;
  assign hz.hazard_flush = flush;
  assign hz.pc_write     = pcw;
  assign hz.idex_bubble  = bub;
  assign hz.mem_stall    = stall;
  assign hz.stall_cnt    = stall_cnt;
  assign hz.flush_cnt    = flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MEM_WAIT=3, CNT_W=16).
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 16;
  localparam int EW = 5 + 2 * CNT_W;

  // {hold, flush, pc_write, bubble, mem_stall}
  localparam logic [4:0] RUNF = 5'b00100;
  localparam logic [4:0] LU   = 5'b10010;
  localparam logic [4:0] BR   = 5'b01110;
  localparam logic [4:0] MS   = 5'b10001;
  localparam logic [4:0] RSTF = 5'b00010;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] ADD  = 32'h010A_4820;
  localparam logic [31:0] JMP  = 32'h0800_0010;
  localparam logic [31:0] BEQ  = 32'h1028_0000;
  localparam logic [31:0] LW   = 32'h8C28_0000;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz();

  pipe_hazard_ctrl #(
    .MEM_WAIT(3),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hz(hz.slave)
  );

  always #5 clock = ~clock;

  logic [EW-1:0]    exp_q[$];
  string            name_q[$];
  int               passed = 0;
  int               total = 0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  task automatic step(
    input logic        rst,
    input logic [31:0] inst,
    input logic        mr,
    input logic [4:0]  rt,
    input logic        br,
    input logic        mo,
    input logic [4:0]  f,
    input bit          chk,
    input string       nm
  );
    reset              = rst;
    hz.id_inst         = inst;
    hz.idex_memread    = mr;
    hz.idex_rt         = rt;
    hz.ex_branch_taken = br;
    hz.exmem_memop     = mo;
    if (chk) begin
      exp_q.push_back({f, m_stall, m_flush});
      name_q.push_back(nm);
    end
    if (!rst) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (f[4] && m_stall != '1) m_stall = m_stall + 1'b1;
      if (f[3] && m_flush != '1) m_flush = m_flush + 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    string         n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {hz.hazard_hold, hz.hazard_flush, hz.pc_write,
           hz.idex_bubble, hz.mem_stall,
           hz.stall_cnt, hz.flush_cnt};
      total++;
      if (a === e) passed++;
      else $display("FAIL %s: got %h expected %h", n, a, e);
    end
  end

  initial begin
    step(0, NOP, 0, 0, 0, 0, RSTF, 0, "rst0");
    step(0, NOP, 0, 0, 0, 0, RSTF, 1, "reset_state");
    step(1, NOP, 0, 0, 0, 0, RUNF, 1, "idle");

    // T1 load-use on rs
    step(1, ADD, 1, 5'd8, 0, 0, LU,   1, "t1_lu_rs");
    step(1, ADD, 0, 5'd8, 0, 0, RUNF, 1, "t1_after");

    // T2 no-hazard cases, rt hazard, lw rt not a source
    step(1, ADD, 1, 5'd0, 0, 0, RUNF, 1, "t2_rt0");
    step(1, JMP, 1, 5'd8, 0, 0, RUNF, 1, "t2_jump");
    step(1, BEQ, 1, 5'd8, 0, 0, LU,   1, "t2_lu_rt");
    step(1, LW,  1, 5'd8, 0, 0, RUNF, 1, "t2_lw_rt");
    step(1, ADD, 0, 5'd8, 0, 0, RUNF, 1, "t2_nomr");

    // T3 branch beats load-use
    step(1, ADD, 1, 5'd8, 1, 0, BR,   1, "t3_br_lu");
    step(1, NOP, 0, 5'd0, 0, 0, RUNF, 1, "t3_after");

    // T4 memop held: 3 stalls, free cycle, retrigger
    step(1, NOP, 0, 0, 0, 1, MS,   1, "t4_ms1");
    step(1, NOP, 0, 0, 0, 1, MS,   1, "t4_ms2");
    step(1, NOP, 0, 0, 0, 1, MS,   1, "t4_ms3");
    step(1, NOP, 0, 0, 0, 1, RUNF, 1, "t4_free");
    step(1, NOP, 0, 0, 0, 1, MS,   1, "t4_re1");
    step(1, NOP, 0, 0, 0, 1, MS,   1, "t4_re2");
    step(1, NOP, 0, 0, 0, 0, MS,   1, "t4_re3");
    step(1, NOP, 0, 0, 0, 0, RUNF, 1, "t4_idle");
    // branch during stall flushes only when unstalled
    step(1, NOP, 0, 0, 0, 1, MS,   1, "t4_br_ms1");
    step(1, NOP, 0, 0, 1, 0, MS,   1, "t4_br_ms2");
    step(1, ADD, 1, 5'd8, 1, 0, MS, 1, "t4_br_ms3");
    step(1, NOP, 0, 0, 1, 0, BR,   1, "t4_br_flush");
    step(1, NOP, 0, 0, 0, 0, RUNF, 1, "t4_br_done");

    // T5 reset mid-WAIT
    step(1, NOP, 0, 0, 0, 1, MS,   1, "t5_ms1");
    step(1, NOP, 0, 0, 0, 0, MS,   1, "t5_ms2");
    step(0, ADD, 1, 5'd8, 1, 0, RSTF, 1, "t5_in_reset");
    step(1, NOP, 0, 0, 0, 0, RUNF, 1, "t5_release");
    step(1, NOP, 0, 0, 0, 1, MS,   1, "t5_retrig");
    step(1, NOP, 0, 0, 0, 0, MS,   1, "t5_retrig2");

    // T6 stall counter saturation
    step(0, NOP, 0, 0, 0, 0, RSTF, 1, "t6_reset");
    for (int i = 0; i < 65540; i++) begin
      step(1, ADD, 1, 5'd8, 0, 0, LU,
           (i == 0) || (i >= 65533), "t6_sat");
    end
    step(1, NOP, 0, 0, 0, 0, RUNF, 1, "t6_hold_sat");

    repeat (3) @(posedge clock);
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d left expected 0", exp_q.size());
    end
    if (m_stall != '1) begin
      total++;
      $display("FAIL t6_model: got %h expected ffff", m_stall);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
